// File: rtl/reg_file_pkg.sv
// Shared defaults and architectural register indices for the MIPS register file.
package reg_file_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;

    localparam int REG_ZERO = 0;
    localparam int REG_V0   = 2;

    typedef logic [ADDR_WIDTH_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits for long-latency results, the reservation handshake
// and a running count of outstanding reservations.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int READ_PORTS = 2,
    parameter int BYPASS     = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] rd_addr,
    output logic [READ_PORTS-1:0]          rd_busy,
    input  logic                           write,
    input  logic [ADDR_WIDTH-1:0]          write_addr,
    input  logic                           reserve,
    input  logic [ADDR_WIDTH-1:0]          reserve_addr,
    output logic                           reserve_ok,
    output logic [ADDR_WIDTH:0]            busy_count
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   busy_d;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   count_d;
    logic                  wr_clr_s;
    logic                  res_set_s;
    logic                  inc_s;
    logic                  dec_s;

    // Next busy vector and counter; a same-address write+reserve leaves the bit set.
    always_comb begin
        wr_clr_s = write && !reset && (write_addr != ZERO_ADDR);
        if (reserve && !reset) begin
            reserve_ok = (reserve_addr == ZERO_ADDR) || !busy_q[reserve_addr]
                         || (write && (write_addr == reserve_addr));
        end else begin
            reserve_ok = 1'b0;
        end
        res_set_s = reserve_ok && (reserve_addr != ZERO_ADDR);
        // The count rises whenever the bit ends set after having been (or being) cleared.
        inc_s = res_set_s && (!busy_q[reserve_addr] || (wr_clr_s && (write_addr == reserve_addr)));
        dec_s = wr_clr_s && busy_q[write_addr];
        for (int i = 0; i < NUM_REGS; i++) begin
            if (res_set_s && (reserve_addr == ADDR_WIDTH'(i))) begin
                busy_d[i] = 1'b1;
            end else if (wr_clr_s && (write_addr == ADDR_WIDTH'(i))) begin
                busy_d[i] = 1'b0;
            end else begin
                busy_d[i] = busy_q[i];
            end
        end
        case ({inc_s, dec_s})
            2'b10:   count_d = count_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{ADDR_WIDTH{1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // Scoreboard state; reset discards every pending reservation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q  <= {NUM_REGS{1'b0}};
            count_q <= {(ADDR_WIDTH+1){1'b0}};
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy_count = count_q;

    for (genvar k = 0; k < READ_PORTS; k++) begin : g_busy
        logic [ADDR_WIDTH-1:0] addr_s;
        logic                  busy_s;

        // Per-port busy flag, optionally seeing a same-cycle completing write.
        always_comb begin
            addr_s = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
            if ((BYPASS != 0) && wr_clr_s && (write_addr == addr_s)) begin
                busy_s = res_set_s && (reserve_addr == addr_s);
            end else begin
                busy_s = busy_q[addr_s];
            end
        end

        assign rd_busy[k] = busy_s;
    end

endmodule

// File: rtl/reg_file_sb.sv
// MIPS general-purpose register file: N combinational read ports, one write
// port, optional write-to-read bypass and a busy scoreboard for decode stalls.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int READ_PORTS = 2,
    parameter int BYPASS     = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] rd_addr,
    output logic [READ_PORTS*DATA_WIDTH-1:0] rd_data,
    output logic [READ_PORTS-1:0]            rd_busy,
    input  logic                             write,
    input  logic [ADDR_WIDTH-1:0]            write_addr,
    input  logic [DATA_WIDTH-1:0]            data_in,
    input  logic                             reserve,
    input  logic [ADDR_WIDTH-1:0]            reserve_addr,
    output logic                             reserve_ok,
    output logic [ADDR_WIDTH:0]              busy_count,
    output logic [DATA_WIDTH-1:0]            register_v0
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);
    localparam logic [ADDR_WIDTH-1:0] V0_ADDR   = ADDR_WIDTH'(REG_V0);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic                  wr_en_s;

    // Storage update; r0 is never written so it stays at its reset value of zero.
    always_comb begin
        wr_en_s = write && !reset && (write_addr != ZERO_ADDR);
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_en_s && (write_addr == ADDR_WIDTH'(i))) begin
                regs_d[i] = data_in;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Register array with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    for (genvar k = 0; k < READ_PORTS; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr_s;
        logic [DATA_WIDTH-1:0] data_s;

        // Read mux with optional same-cycle forwarding of the write port.
        always_comb begin
            addr_s = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
            if ((BYPASS != 0) && wr_en_s && (write_addr == addr_s)) begin
                data_s = data_in;
            end else begin
                data_s = regs_q[addr_s];
            end
        end

        assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = data_s;
    end

    assign register_v0 = regs_q[V0_ADDR];

    reg_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .READ_PORTS (READ_PORTS),
        .BYPASS     (BYPASS)
    ) u_scoreboard (
        .clk          (clk),
        .reset        (reset),
        .rd_addr      (rd_addr),
        .rd_busy      (rd_busy),
        .write        (write),
        .write_addr   (write_addr),
        .reserve      (reserve),
        .reserve_addr (reserve_addr),
        .reserve_ok   (reserve_ok),
        .busy_count   (busy_count)
    );

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised MIPS general-purpose register file with N combinational read ports, one write port, optional same-cycle write-to-read bypass and a per-register busy scoreboard for long-latency results (loads, multiply/divide). It sits in the CPU datapath in place of the fixed 2-read/32x32 register file. Decode uses the `rd_busy` flags to stall on RAW hazards against outstanding results.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register address width; NUM_REGS = 2**ADDR_WIDTH
- READ_PORTS, 2, number of read ports (>=1)
- BYPASS, 1, 1 = a same-cycle write is visible on the read ports

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- rd_addr  in  READ_PORTS*ADDR_WIDTH  packed read addresses; port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- rd_data  out  READ_PORTS*DATA_WIDTH  packed read data, same packing
- rd_busy  out  READ_PORTS  port k address has an outstanding reservation
- write  in  1  write enable
- write_addr  in  ADDR_WIDTH  write address
- data_in  in  DATA_WIDTH  write data
- reserve  in  1  request to mark reserve_addr busy
- reserve_addr  in  ADDR_WIDTH  register to reserve
- reserve_ok  out  1  reservation accepted this cycle (combinational)
- busy_count  out  ADDR_WIDTH+1  number of currently busy registers
- register_v0  out  DATA_WIDTH  current committed value of register 2 (test observation)

## Operation
- Register 0: reads 0, never busy; writes and reservations to 0 are ignored (reserve_ok = 1, no state change).
- Read k: rd_data = regs[rd_addr_k]. If BYPASS and write && write_addr == rd_addr_k != 0: rd_data = data_in and rd_busy_k = 0 unless that address is also being newly reserved in the same cycle.
- Write: on rising edge with write && write_addr != 0, regs[write_addr] <= data_in and busy[write_addr] <= 0. Writing a non-busy register is legal (ordinary single-cycle result).
- Reserve: reserve_ok = reserve && (reserve_addr == 0 || !busy[reserve_addr] || (write && write_addr == reserve_addr)). When accepted with reserve_addr != 0, busy[reserve_addr] <= 1. When rejected, no state change; issuer retries.
- Write and reserve on the same address, same cycle: data is written and busy ends set (new reservation wins).
- busy_count: +1 on an accepted nonzero reservation of a non-busy register, -1 on a write clearing a busy bit; both in one cycle -> unchanged. Always equals popcount(busy). Never exceeds NUM_REGS-1.
- register_v0 ignores bypass.

## Timing
- Reads, rd_busy and reserve_ok: combinational, zero latency.
- Writes and reservations take effect at the next rising edge; visible without bypass one cycle later.
- Reset (asynchronous, any time including mid-operation): regs = 0, busy = 0, busy_count = 0; therefore rd_data = 0, rd_busy = 0, register_v0 = 0 immediately. Write/reserve are ignored while reset is high. Pending reservations are discarded.
- No X on outputs after reset for any address.

## Structure
- Package reg_file_pkg: default DATA_WIDTH/ADDR_WIDTH, reg_addr_t typedef, constants REG_ZERO = 0, REG_V0 = 2.
- Sub-module reg_scoreboard: busy bit vector, reserve_ok logic and busy_count counter; shares clk/reset, takes write/reserve controls and read addresses, returns rd_busy.
- Storage array and read muxes (generate loop over READ_PORTS) stay in reg_file_sb.

## Test plan
- Reset mid-run after writing 0xDEADBEEF to r2: outputs (register_v0, rd_data, rd_busy, busy_count) are 0 immediately, before the next edge.
- Write r0 = 5, read r0 -> 0; write r2 = 0x1234 while port 1 reads r2 -> rd_data = 0x1234 same cycle (BYPASS=1), previous value with BYPASS=0; register_v0 = 0x1234 next cycle.
- Reserve r8 -> reserve_ok = 1, busy_count 1, rd_busy set for port reading r8; second reserve r8 -> reserve_ok = 0, count stays 1; write r8 = 7 -> busy cleared, count 0, rd_data 7.
- Same cycle: write r9 (busy) and reserve r9 -> reserve_ok = 1, r9 holds new data, still busy, count unchanged.
- READ_PORTS=4, ADDR_WIDTH=4: reserve r1..r15 -> count 15; write all -> count 0; four ports read distinct registers correctly.
